// File: rtl/t06_button_event_arbiter.sv
// Debounced multi-channel button front end with round-robin event serializer.
// Latency: btn rise to evt_valid is 3 clk edges after the first sampling edge (2 sync + pending stage).
// Backpressure: evt_valid/evt_code hold while evt_ready is low; new edges keep accumulating as pending bits.
//
// Ports:
//   clk, nrst         - clock (rising edge) and asynchronous active-low reset
//   btn[N_BTN]        - raw asynchronous button levels, 1 = pressed
//   evt_valid/evt_ready/evt_code - registered valid/ready event port, code = channel index
//   overflow, clr_ovf - sticky "edge hit an already-pending channel" flag and its synchronous clear
module t06_button_event_arbiter #(
    parameter int N_BTN      = 8,
    parameter int CODE_W     = 3,
    parameter int DEB_W      = 8,
    parameter int DEB_CYCLES = 200
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [N_BTN-1:0]  btn,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CODE_W-1:0] evt_code,
    output logic              overflow,
    input  logic              clr_ovf
);

    logic [N_BTN-1:0]  s1_q, s1_d;
    logic [N_BTN-1:0]  s2_q, s2_d;
    logic [N_BTN-1:0]  prev_q, prev_d;
    logic [N_BTN-1:0]  pending_q, pending_d;
    logic [DEB_W-1:0]  lock_q [N_BTN];
    logic [DEB_W-1:0]  lock_d [N_BTN];
    logic [CODE_W-1:0] ptr_q, ptr_d;
    logic              evt_valid_q, evt_valid_d;
    logic [CODE_W-1:0] evt_code_q, evt_code_d;
    logic              overflow_q, overflow_d;

    logic [N_BTN-1:0]  edge_det;
    logic [N_BTN-1:0]  grant_mask;
    logic              found;
    logic [CODE_W-1:0] sel;
    logic              load;

    // Synchronizer, edge detect and per-channel lockout. prev follows s2 even
    // while locked, so a level still high when the lockout ends is not an edge.
    always_comb begin
        s1_d   = btn;
        s2_d   = s1_q;
        prev_d = s2_q;
        for (int i = 0; i < N_BTN; i++) begin
            edge_det[i] = s2_q[i] & ~prev_q[i] & (lock_q[i] == '0);
            if (edge_det[i]) begin
                lock_d[i] = DEB_W'(DEB_CYCLES);
            end else if (lock_q[i] != '0) begin
                lock_d[i] = lock_q[i] - DEB_W'(1);
            end else begin
                lock_d[i] = '0;
            end
        end
    end

    // Round-robin search starting at ptr, wrapping modulo N_BTN.
    always_comb begin : rr_search
        int idx;
        idx   = 0;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < N_BTN; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_BTN) begin
                idx = idx - N_BTN;
            end
            if (!found && pending_q[idx]) begin
                found = 1'b1;
                sel   = CODE_W'(idx);
            end
        end
    end

    // Output register reloads when empty or when the current event is taken.
    always_comb begin
        load        = ~evt_valid_q | evt_ready;
        grant_mask  = '0;
        evt_valid_d = evt_valid_q;
        evt_code_d  = evt_code_q;
        ptr_d       = ptr_q;
        if (load) begin
            evt_valid_d = found;
            if (found) begin
                evt_code_d = sel;
                grant_mask = N_BTN'(1) << sel;
                ptr_d      = (sel == CODE_W'(N_BTN - 1)) ? '0 : sel + CODE_W'(1);
            end
        end
        // A fresh edge on the channel being granted keeps its pending bit.
        pending_d = (pending_q & ~grant_mask) | edge_det;
        // Set beats clear so an overflow coinciding with clr_ovf is not lost.
        if (|(edge_det & pending_q)) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            prev_q      <= '0;
            pending_q   <= '0;
            ptr_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_code_q  <= '0;
            overflow_q  <= 1'b0;
            for (int i = 0; i < N_BTN; i++) begin
                lock_q[i] <= '0;
            end
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            prev_q      <= prev_d;
            pending_q   <= pending_d;
            ptr_q       <= ptr_d;
            evt_valid_q <= evt_valid_d;
            evt_code_q  <= evt_code_d;
            overflow_q  <= overflow_d;
            for (int i = 0; i < N_BTN; i++) begin
                lock_q[i] <= lock_d[i];
            end
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_code  = evt_code_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_t06_button_event_arbiter.sv
// Directed bench for t06_button_event_arbiter.
// Inputs change and outputs are sampled 1 time unit after each rising clk edge.
// Counts checks in total/bad and prints one summary line.
module tb_t06_button_event_arbiter;

    logic       clk;
    logic       nrst;
    logic [7:0] btn;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_code;
    logic       overflow;
    logic       clr_ovf;

    int total = 0;
    int bad   = 0;

    t06_button_event_arbiter #(
        .N_BTN(8), .CODE_W(3), .DEB_W(8), .DEB_CYCLES(200)
    ) dut (
        .clk(clk), .nrst(nrst), .btn(btn),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
        .overflow(overflow), .clr_ovf(clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        nrst = 1'b0;
        tick;
        tick;
        nrst = 1'b1;
    endtask

    task automatic test_reset;
        btn = '0; evt_ready = 1'b0; clr_ovf = 1'b0; nrst = 1'b0;
        tick; tick;
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", evt_valid); end
        total++; if (evt_code !== 3'd0) begin bad++; $display("FAIL rst_code: got %0d want 0", evt_code); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", overflow); end
        nrst = 1'b1;
        repeat (10) tick;
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL idle_valid: got %b want 0", evt_valid); end
        total++; if (evt_code !== 3'd0) begin bad++; $display("FAIL idle_code: got %0d want 0", evt_code); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL idle_ovf: got %b want 0", overflow); end
    endtask

    task automatic test_single;
        int n;
        do_reset;
        evt_ready = 1'b1;
        btn = 8'b0010_0000;
        for (int e = 0; e < 3; e++) begin
            tick;
            total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL single_early edge%0d: got %b want 0", e, evt_valid); end
        end
        tick;
        total++; if (evt_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", evt_valid); end
        total++; if (evt_code !== 3'd5) begin bad++; $display("FAIL single_code: got %0d want 5", evt_code); end
        tick;
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL single_drop: got %b want 0", evt_valid); end
        btn = '0;
        n = 0;
        repeat (20) begin tick; if (evt_valid) n++; end
        total++; if (n != 0) begin bad++; $display("FAIL single_extra: got %0d events want 0", n); end
    endtask

    task automatic test_stall;
        do_reset;
        evt_ready = 1'b0;
        btn = 8'b0100_0010;
        repeat (3) tick;
        for (int s = 0; s < 5; s++) begin
            tick;
            total++; if (evt_valid !== 1'b1 || evt_code !== 3'd1) begin
                bad++; $display("FAIL stall_hold cyc%0d: got v=%b c=%0d want v=1 c=1", s, evt_valid, evt_code);
            end
        end
        evt_ready = 1'b1;
        tick;
        total++; if (evt_valid !== 1'b1 || evt_code !== 3'd6) begin
            bad++; $display("FAIL stall_second: got v=%b c=%0d want v=1 c=6", evt_valid, evt_code);
        end
        tick;
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL stall_empty: got %b want 0", evt_valid); end
        btn = '0;
    endtask

    task automatic test_round_robin;
        int n;
        do_reset;
        evt_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            btn = 8'hFF;
            repeat (3) tick;
            for (int k = 0; k < 8; k++) begin
                tick;
                total++; if (evt_valid !== 1'b1 || evt_code !== 3'(k)) begin
                    bad++; $display("FAIL rr_grant r%0d k%0d: got v=%b c=%0d want v=1 c=%0d", r, k, evt_valid, evt_code, k);
                end
            end
            tick;
            total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL rr_empty r%0d: got %b want 0", r, evt_valid); end
            btn = '0;
            n = 0;
            repeat (200) begin tick; if (evt_valid) n++; end
            total++; if (n != 0) begin bad++; $display("FAIL rr_quiet r%0d: got %0d events want 0", r, n); end
        end
    endtask

    task automatic test_bounce;
        int n;
        int wrong;
        do_reset;
        evt_ready = 1'b1;
        n = 0; wrong = 0;
        for (int c = 0; c < 50; c++) begin
            btn = '0;
            if (c < 40) btn[2] = ((c / 3) % 2) == 0;
            tick;
            if (evt_valid) begin
                n++;
                if (evt_code !== 3'd2) wrong++;
            end
        end
        total++; if (n != 1) begin bad++; $display("FAIL bounce_count: got %0d events want 1", n); end
        total++; if (wrong != 0) begin bad++; $display("FAIL bounce_code: got %0d wrong codes want 0", wrong); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL bounce_ovf: got %b want 0", overflow); end
        btn = '0;
    endtask

    task automatic test_overflow;
        int n;
        do_reset;
        evt_ready = 1'b0;
        btn = 8'b0000_1001;
        repeat (4) tick;
        total++; if (evt_valid !== 1'b1 || evt_code !== 3'd0) begin
            bad++; $display("FAIL ovf_first: got v=%b c=%0d want v=1 c=0", evt_valid, evt_code);
        end
        btn = '0;
        repeat (205) tick;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_before: got %b want 0", overflow); end
        btn = 8'b0000_1000;
        repeat (4) tick;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
        total++; if (evt_valid !== 1'b1 || evt_code !== 3'd0) begin
            bad++; $display("FAIL ovf_hold: got v=%b c=%0d want v=1 c=0", evt_valid, evt_code);
        end
        evt_ready = 1'b1;
        tick;
        total++; if (evt_valid !== 1'b1 || evt_code !== 3'd3) begin
            bad++; $display("FAIL ovf_code3: got v=%b c=%0d want v=1 c=3", evt_valid, evt_code);
        end
        btn = '0;
        n = 0;
        repeat (10) begin tick; if (evt_valid) n++; end
        total++; if (n != 0) begin bad++; $display("FAIL ovf_single: got %0d extra events want 0", n); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        clr_ovf = 1'b1;
        tick;
        clr_ovf = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    endtask

    task automatic test_reset_mid;
        int n;
        int n4;
        do_reset;
        evt_ready = 1'b0;
        btn = 8'b0001_0110;
        repeat (4) tick;
        total++; if (evt_valid !== 1'b1 || evt_code !== 3'd1) begin
            bad++; $display("FAIL mid_pre: got v=%b c=%0d want v=1 c=1", evt_valid, evt_code);
        end
        btn = 8'b0001_0000;
        nrst = 1'b0;
        #1;
        total++; if (evt_valid !== 1'b0 || evt_code !== 3'd0 || overflow !== 1'b0) begin
            bad++; $display("FAIL mid_async: got v=%b c=%0d o=%b want all 0", evt_valid, evt_code, overflow);
        end
        tick; tick;
        nrst = 1'b1;
        evt_ready = 1'b1;
        n = 0; n4 = 0;
        repeat (15) begin
            tick;
            if (evt_valid) begin
                n++;
                if (evt_code === 3'd4) n4++;
            end
        end
        total++; if (n != 1) begin bad++; $display("FAIL mid_count: got %0d events want 1", n); end
        total++; if (n4 != 1) begin bad++; $display("FAIL mid_code4: got %0d code-4 events want 1", n4); end
        btn = '0;
    endtask

    initial begin
        test_reset;
        test_single;
        test_stall;
        test_round_robin;
        test_bounce;
        test_overflow;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
